// File: rtl/wb_shared_arbiter_pkg.sv
// Shared definitions for the Wishbone shared-bus arbiter.
//   arb_state_e : arbiter FSM state encoding
//   SEL_W       : byte-select width for the default 32-bit data path
//   sel_width() : byte-select width for an arbitrary data width
package wb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_ABORT = 2'd2
   } arb_state_e;

   localparam int DATA_W_DFLT = 32;
   localparam int SEL_W       = DATA_W_DFLT / 8;

   function automatic int sel_width(input int data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/wb_shared_arbiter_if.sv
// Bus bundle between the N Wishbone masters, the arbiter and the shared slave.
//   m_* : packed per-master request signals (master k at slice k) and the
//         per-master responses; m_dat_o is broadcast
//   s_* : single slave-side port
// modport slave  : arbiter view (accepts master requests, drives the slave)
// modport master : environment view (masters plus the shared slave)
interface wb_shared_arbiter_if
   import wb_pkg::*;
#(
   parameter int NUM_MASTERS = 4,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32
);
   localparam int SW = sel_width(DATA_W);

   logic [NUM_MASTERS-1:0]        m_cyc_i;
   logic [NUM_MASTERS-1:0]        m_stb_i;
   logic [NUM_MASTERS-1:0]        m_we_i;
   logic [NUM_MASTERS*SW-1:0]     m_sel_i;
   logic [NUM_MASTERS*ADDR_W-1:0] m_adr_i;
   logic [NUM_MASTERS*DATA_W-1:0] m_dat_i;
   logic [DATA_W-1:0]             m_dat_o;
   logic [NUM_MASTERS-1:0]        m_ack_o;
   logic [NUM_MASTERS-1:0]        m_err_o;

   logic                          s_cyc_o;
   logic                          s_stb_o;
   logic                          s_we_o;
   logic [SW-1:0]                 s_sel_o;
   logic [ADDR_W-1:0]             s_adr_o;
   logic [DATA_W-1:0]             s_dat_o;
   logic [DATA_W-1:0]             s_dat_i;
   logic                          s_ack_i;
   logic                          s_err_i;

   modport slave (
      input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
      output m_dat_o, m_ack_o, m_err_o,
      output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
      input  s_dat_i, s_ack_i, s_err_i
   );

   modport master (
      output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
      input  m_dat_o, m_ack_o, m_err_o,
      input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
      output s_dat_i, s_ack_i, s_err_i
   );

endinterface

// File: rtl/wb_shared_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req_i   : request vector
//   ptr_i   : index with highest priority this round
//   gnt_o   : one-hot winner, first requester at or after ptr_i (with wrap)
//   valid_o : at least one request present
module rr_pick #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic          valid_o
);

   int idx;

   always_comb begin
      gnt_o   = '0;
      valid_o = 1'b0;
      idx     = 0;
      for (int i = 0; i < N; i++) begin
         idx = int'(ptr_i) + i;
         if (idx >= N) idx = idx - N;
         if (!valid_o && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
            valid_o    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_shared_arbiter.sv
// N-master to 1-slave Wishbone classic arbiter with round-robin grant,
// cycle-long bus lock and a per-transaction watchdog.
//   wb_clk_i  : bus clock
//   wb_rst_ni : asynchronous active-low reset
//   bus       : master request/response bundle and shared slave port
//   grant_o   : one-hot current owner, zero when idle
//   timeout_o : one-cycle pulse when the watchdog aborts a transfer
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no owner; round-robin pick among cyc&stb requesters
// ST_GRANT | owner's signals routed to the slave while its cyc is high
// ST_ABORT | watchdog expired: slave cut off, err to owner for one cycle
module wb_shared_arbiter
   import wb_pkg::*;
#(
   parameter int NUM_MASTERS    = 4,
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_ni,
   wb_shared_arbiter_if.slave     bus,
   output logic [NUM_MASTERS-1:0] grant_o,
   output logic                   timeout_o
);

   localparam int SW  = sel_width(DATA_W);
   localparam int PW  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int WDW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic           WD_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [WDW-1:0] WD_LOAD = WDW'(TIMEOUT_CYCLES);

   arb_state_e             state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [PW-1:0]          gidx_q, gidx_d;
   logic [PW-1:0]          ptr_q, ptr_d;
   logic [WDW-1:0]         wdog_q, wdog_d;

   logic [NUM_MASTERS-1:0] req;
   logic [NUM_MASTERS-1:0] pick_gnt;
   logic                   pick_valid;
   logic [PW-1:0]          pick_idx;
   logic [PW-1:0]          next_ptr;
   logic                   in_grant;
   logic                   in_abort;
   logic                   own_cyc;
   logic                   stall;

   assign req = bus.m_cyc_i & bus.m_stb_i;

   rr_pick #(
      .N  (NUM_MASTERS),
      .PW (PW)
   ) u_pick (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .gnt_o   (pick_gnt),
      .valid_o (pick_valid)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (pick_gnt[i]) pick_idx = PW'(i);
      end
   end

   assign in_grant = (state_q == ST_GRANT);
   assign in_abort = (state_q == ST_ABORT);
   assign own_cyc  = bus.m_cyc_i[gidx_q];

   // Slave side follows the owner combinationally; forced low outside GRANT
   // so a reset or an abort cuts the slave off without waiting for an edge.
   assign bus.s_cyc_o = in_grant & own_cyc;
   assign bus.s_stb_o = in_grant & bus.m_stb_i[gidx_q];
   assign bus.s_we_o  = in_grant & bus.m_we_i[gidx_q];
   assign bus.s_sel_o = in_grant ? bus.m_sel_i[gidx_q*SW +: SW]         : '0;
   assign bus.s_adr_o = in_grant ? bus.m_adr_i[gidx_q*ADDR_W +: ADDR_W] : '0;
   assign bus.s_dat_o = in_grant ? bus.m_dat_i[gidx_q*DATA_W +: DATA_W] : '0;

   assign bus.m_dat_o = bus.s_dat_i;
   assign bus.m_ack_o = in_grant ? (grant_q & {NUM_MASTERS{bus.s_ack_i}}) : '0;
   assign bus.m_err_o = in_grant ? (grant_q & {NUM_MASTERS{bus.s_err_i}}) :
                        in_abort ? grant_q : '0;

   assign grant_o   = grant_q;
   assign timeout_o = in_abort;

   // An ack/err in the same cycle is never a stall, so it always beats expiry.
   assign stall    = bus.s_stb_o & ~bus.s_ack_i & ~bus.s_err_i;
   assign next_ptr = (gidx_q == PW'(NUM_MASTERS - 1)) ? '0 : gidx_q + 1'b1;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      gidx_d  = gidx_q;
      ptr_d   = ptr_q;
      wdog_d  = wdog_q;
      unique case (state_q)
         ST_IDLE: begin
            wdog_d = WD_LOAD;
            if (pick_valid) begin
               state_d = ST_GRANT;
               grant_d = pick_gnt;
               gidx_d  = pick_idx;
            end
         end
         ST_GRANT: begin
            if (!own_cyc) begin
               state_d = ST_IDLE;
               grant_d = '0;
               ptr_d   = next_ptr;
               wdog_d  = WD_LOAD;
            end else if (WD_EN && stall) begin
               // Down-counter holds remaining stall cycles; terminal count is 1.
               if (wdog_q == WDW'(1)) begin
                  state_d = ST_ABORT;
                  wdog_d  = WD_LOAD;
               end else begin
                  wdog_d = wdog_q - 1'b1;
               end
            end else if (bus.s_ack_i || bus.s_err_i) begin
               wdog_d = WD_LOAD;
            end
         end
         ST_ABORT: begin
            state_d = ST_IDLE;
            grant_d = '0;
            ptr_d   = next_ptr;
            wdog_d  = WD_LOAD;
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         gidx_q  <= '0;
         ptr_q   <= '0;
         wdog_q  <= WD_LOAD;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         ptr_q   <= ptr_d;
         wdog_q  <= wdog_d;
      end
   end

endmodule

// File: tb/tb_wb_shared_arbiter.sv
// Directed bench for wb_shared_arbiter: 4 masters, 8-cycle watchdog.
module tb_wb_shared_arbiter;

   localparam int NM = 4;

   logic          wb_clk_i;
   logic          wb_rst_ni;
   logic [NM-1:0] grant_o;
   logic          timeout_o;
   logic          ack_auto;
   logic          ack_man;

   int total;
   int bad;
   int wait_n;
   int exp_ord [5] = '{0, 1, 2, 3, 0};

   wb_shared_arbiter_if #(.NUM_MASTERS(NM), .ADDR_W(32), .DATA_W(32)) bus ();

   wb_shared_arbiter #(
      .NUM_MASTERS    (NM),
      .ADDR_W         (32),
      .DATA_W         (32),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_ni (wb_rst_ni),
      .bus       (bus),
      .grant_o   (grant_o),
      .timeout_o (timeout_o)
   );

   // Auto mode: slave acks whenever someone owns the bus.
   assign bus.s_ack_i = ack_auto ? (|grant_o) : ack_man;

   initial wb_clk_i = 1'b0;
   always #5 wb_clk_i = ~wb_clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
      total++;
      if (obs !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, want);
      end
   endtask

   task automatic set_m(input int k, input logic cyc, input logic stb, input logic we,
                        input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
      bus.m_cyc_i[k]          = cyc;
      bus.m_stb_i[k]          = stb;
      bus.m_we_i[k]           = we;
      bus.m_sel_i[k*4 +: 4]   = sel;
      bus.m_adr_i[k*32 +: 32] = adr;
      bus.m_dat_i[k*32 +: 32] = dat;
   endtask

   task automatic clr_all();
      for (int k = 0; k < NM; k++) set_m(k, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
   endtask

   task automatic tick();
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic do_reset();
      clr_all();
      ack_auto      = 1'b0;
      ack_man       = 1'b0;
      bus.s_err_i   = 1'b0;
      bus.s_dat_i   = '0;
      wb_rst_ni     = 1'b0;
      repeat (2) @(posedge wb_clk_i);
      #1;
      wb_rst_ni = 1'b1;
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      wait_n      = 0;
      wb_rst_ni   = 1'b0;
      ack_auto    = 1'b0;
      ack_man     = 1'b0;
      bus.s_err_i = 1'b0;
      bus.s_dat_i = '0;
      clr_all();
      #2;
      chk("rst_grant",   64'(grant_o),       64'h0);
      chk("rst_scyc",    64'(bus.s_cyc_o),   64'h0);
      chk("rst_timeout", 64'(timeout_o),     64'h0);
      chk("rst_ack",     64'(bus.m_ack_o),   64'h0);

      // single master read, slave acks in second GRANT cycle
      do_reset();
      set_m(0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h3000_0010, 32'h0);
      @(negedge wb_clk_i);
      chk("single_idle_stb", 64'(bus.s_stb_o), 64'h0);
      tick();
      @(negedge wb_clk_i);
      chk("single_stb",   64'(bus.s_stb_o), 64'h1);
      chk("single_grant", 64'(grant_o),     64'h1);
      chk("single_adr",   64'(bus.s_adr_o), 64'h3000_0010);
      chk("single_noack", 64'(bus.m_ack_o), 64'h0);
      tick();
      ack_man     = 1'b1;
      bus.s_dat_i = 32'hA5A5_0001;
      @(negedge wb_clk_i);
      chk("single_ack", 64'(bus.m_ack_o), 64'h1);
      chk("single_dat", 64'(bus.m_dat_o), 64'hA5A5_0001);
      tick();
      ack_man = 1'b0;
      set_m(0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge wb_clk_i);
      chk("single_scyc_drop", 64'(bus.s_cyc_o), 64'h0);
      tick();
      @(negedge wb_clk_i);
      chk("single_release", 64'(grant_o), 64'h0);

      // contention: all four write continuously, round-robin order expected
      do_reset();
      ack_auto = 1'b1;
      for (int k = 0; k < NM; k++) set_m(k, 1'b1, 1'b1, 1'b1, 4'hF, 32'h1000 + k, k);
      for (int g = 0; g < 5; g++) begin
         wait_n = 0;
         @(negedge wb_clk_i);
         while (grant_o == '0 && wait_n < 8) begin
            @(negedge wb_clk_i);
            wait_n++;
         end
         chk("rr_order", 64'(grant_o),     64'(1) << exp_ord[g]);
         chk("rr_adr",   64'(bus.s_adr_o), 64'h1000 + 64'(exp_ord[g]));
         chk("rr_we",    64'(bus.s_we_o),  64'h1);
         chk("rr_ack",   64'(bus.m_ack_o), 64'(1) << exp_ord[g]);
         tick();
         set_m(exp_ord[g], 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
         tick();
         set_m(exp_ord[g], 1'b1, 1'b1, 1'b1, 4'hF, 32'h1000 + exp_ord[g], exp_ord[g]);
         @(negedge wb_clk_i);
         chk("rr_dead", 64'(grant_o), 64'h0);
      end
      clr_all();
      tick();
      tick();

      // lock: m1 holds cyc over three beats while m2 waits
      do_reset();
      ack_auto = 1'b1;
      set_m(1, 1'b1, 1'b1, 1'b1, 4'b0011, 32'h2000, 32'h11);
      set_m(2, 1'b1, 1'b1, 1'b1, 4'b1111, 32'h2100, 32'h22);
      tick();
      @(negedge wb_clk_i);
      chk("lock_g1", 64'(grant_o),     64'h2);
      chk("lock_s1", 64'(bus.s_sel_o), 64'h3);
      chk("lock_a1", 64'(bus.m_ack_o), 64'h2);
      tick();
      set_m(1, 1'b1, 1'b1, 1'b1, 4'b1100, 32'h2000, 32'h11);
      @(negedge wb_clk_i);
      chk("lock_g2", 64'(grant_o),     64'h2);
      chk("lock_s2", 64'(bus.s_sel_o), 64'hC);
      tick();
      set_m(1, 1'b1, 1'b1, 1'b1, 4'b1111, 32'h2000, 32'h11);
      @(negedge wb_clk_i);
      chk("lock_g3", 64'(grant_o),     64'h2);
      chk("lock_s3", 64'(bus.s_sel_o), 64'hF);
      tick();
      set_m(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge wb_clk_i);
      chk("lock_hold_to_edge", 64'(grant_o), 64'h2);
      tick();
      @(negedge wb_clk_i);
      chk("lock_dead", 64'(grant_o), 64'h0);
      tick();
      @(negedge wb_clk_i);
      chk("lock_next", 64'(grant_o),     64'h4);
      chk("lock_dat2", 64'(bus.s_dat_o), 64'h22);
      clr_all();
      tick();
      tick();

      // watchdog expiry on m2, m3 waiting behind it
      do_reset();
      set_m(2, 1'b1, 1'b1, 1'b0, 4'hF, 32'h4000, 32'h0);
      set_m(3, 1'b1, 1'b1, 1'b0, 4'hF, 32'h4100, 32'h0);
      @(posedge wb_clk_i);
      repeat (8) begin
         @(negedge wb_clk_i);
         chk("wd_run_timeout", 64'(timeout_o),   64'h0);
         chk("wd_run_scyc",    64'(bus.s_cyc_o), 64'h1);
      end
      @(negedge wb_clk_i);
      chk("wd_timeout", 64'(timeout_o),   64'h1);
      chk("wd_err",     64'(bus.m_err_o), 64'h4);
      chk("wd_scyc",    64'(bus.s_cyc_o), 64'h0);
      chk("wd_grant",   64'(grant_o),     64'h4);
      tick();
      set_m(2, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge wb_clk_i);
      chk("wd_pulse_once", 64'(timeout_o), 64'h0);
      chk("wd_idle",       64'(grant_o),   64'h0);
      @(negedge wb_clk_i);
      chk("wd_next", 64'(grant_o), 64'h8);
      tick();
      clr_all();
      tick();
      tick();

      // ack exactly on the eighth stalled cycle beats the watchdog
      do_reset();
      set_m(2, 1'b1, 1'b1, 1'b0, 4'hF, 32'h5000, 32'h0);
      @(posedge wb_clk_i);
      repeat (7) @(negedge wb_clk_i);
      tick();
      ack_man     = 1'b1;
      bus.s_dat_i = 32'h5A5A_0002;
      @(negedge wb_clk_i);
      chk("bnd_ack",     64'(bus.m_ack_o), 64'h4);
      chk("bnd_err",     64'(bus.m_err_o), 64'h0);
      chk("bnd_timeout", 64'(timeout_o),   64'h0);
      chk("bnd_dat",     64'(bus.m_dat_o), 64'h5A5A_0002);
      tick();
      ack_man = 1'b0;
      set_m(2, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge wb_clk_i);
      chk("bnd_after_timeout", 64'(timeout_o),   64'h0);
      chk("bnd_after_err",     64'(bus.m_err_o), 64'h0);
      chk("bnd_after_grant",   64'(grant_o),     64'h4);
      tick();

      // reset while m3 owns the bus; pointer must restart at m0
      set_m(3, 1'b1, 1'b1, 1'b0, 4'hF, 32'h6000, 32'h0);
      tick();
      @(negedge wb_clk_i);
      chk("rmid_pre_grant", 64'(grant_o), 64'h8);
      #2;
      ack_man   = 1'b1;
      wb_rst_ni = 1'b0;
      #1;
      chk("rmid_scyc",  64'(bus.s_cyc_o), 64'h0);
      chk("rmid_grant", 64'(grant_o),     64'h0);
      chk("rmid_ack",   64'(bus.m_ack_o), 64'h0);
      ack_man = 1'b0;
      for (int k = 0; k < NM; k++) set_m(k, 1'b1, 1'b1, 1'b0, 4'hF, 32'h7000 + k, 32'h0);
      tick();
      wb_rst_ni = 1'b1;
      @(negedge wb_clk_i);
      chk("rmid_idle", 64'(grant_o), 64'h0);
      @(negedge wb_clk_i);
      chk("rmid_first", 64'(grant_o), 64'h1);
      clr_all();
      tick();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wb_shared_arbiter.md
Name: wb_shared_arbiter

Overview:
- Parametrised N-master to 1-slave Wishbone classic arbiter.
- Lets NUM_MASTERS rv_core instances share one peripheral bus. Each core's shared_* master port lands on one master slot here.
- Features: fair round-robin grant, bus lock for the whole cycle (cyc) duration, per-transaction watchdog that terminates hung slaves with an error.
- Sits between the per-core wishbone muxes and the shared peripheral interconnect.

Parameters:
- NUM_MASTERS, 4, number of master ports (2..16).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; a multiple of 8.
- TIMEOUT_CYCLES, 255, cycles in GRANT without ack/err before forced error; 0 disables the watchdog.

Ports:
- wb_clk_i  in  1  bus clock.
- wb_rst_ni  in  1  reset, asynchronous, active-low.
- m_cyc_i  in  NUM_MASTERS  per-master cyc.
- m_stb_i  in  NUM_MASTERS  per-master stb.
- m_we_i  in  NUM_MASTERS  per-master write enable.
- m_sel_i  in  NUM_MASTERS*DATA_W/8  packed byte selects; master k at slice k.
- m_adr_i  in  NUM_MASTERS*ADDR_W  packed addresses.
- m_dat_i  in  NUM_MASTERS*DATA_W  packed write data.
- m_dat_o  out  DATA_W  read data, broadcast to all masters.
- m_ack_o  out  NUM_MASTERS  per-master ack.
- m_err_o  out  NUM_MASTERS  per-master error.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave-side controls.
- s_sel_o  out  DATA_W/8  slave byte selects.
- s_adr_o  out  ADDR_W  slave address.
- s_dat_o  out  DATA_W  slave write data.
- s_dat_i  in  DATA_W  slave read data.
- s_ack_i, s_err_i  in  1 each  slave responses.
- grant_o  out  NUM_MASTERS  one-hot current owner; all zero when idle.
- timeout_o  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset (asynchronous, wb_rst_ni low):
  - state=IDLE, grant_o=0, priority pointer=0, watchdog=0.
  - All s_* control outputs low; m_ack_o=0, m_err_o=0, timeout_o=0.
  - Reset mid-transaction drops s_cyc_o/s_stb_o immediately; no ack is delivered.
- States: IDLE, GRANT, ABORT.
- IDLE:
  - Requesters are the masters with m_cyc_i&m_stb_i.
  - Winner is the first requester at or after the pointer, in ascending index with wrap.
  - Winner is registered into grant_o; state becomes GRANT next edge.
  - Grant latency: one cycle from request to s_stb_o.
- GRANT:
  - s_cyc_o/s_stb_o/s_we_o/s_sel_o/s_adr_o/s_dat_o = the granted master's m_cyc_i/m_stb_i/m_we_i/m_sel_i/m_adr_i/m_dat_i, combinational.
  - s_ack_i and s_err_i route combinationally to the granted master's m_ack_o/m_err_o. m_dat_o = s_dat_i.
  - Grant is held while the granted m_cyc_i stays high, so multi-beat and RMW sequences are locked.
  - When the granted m_cyc_i is low at an edge: go to IDLE, pointer = granted index + 1 (mod NUM_MASTERS). This gives one dead cycle between owners.
- Watchdog:
  - Counts cycles in GRANT with s_stb_o high and no s_ack_i/s_err_i; clears on ack, err, or leaving GRANT.
  - When it reaches TIMEOUT_CYCLES: go to ABORT.
- ABORT (one cycle):
  - s_cyc_o=s_stb_o=0; m_err_o[granted]=1; timeout_o=1.
  - Next state IDLE; pointer advances as on normal release.
  - An s_ack_i arriving during ABORT is ignored.
- Simultaneous events:
  - Ack and watchdog expiry on the same cycle: the ack wins and the counter clears.
  - A non-granted master requesting during GRANT is stalled with no ack/err until granted.
  - Granted master dropping stb while keeping cyc: lock is held, s_stb_o=0, watchdog paused.
- Non-granted masters always see m_ack_o=m_err_o=0.

Decomposition:
- Shared package (wb_pkg): the arbiter state encoding (IDLE/GRANT/ABORT) and the localparam SEL_W=DATA_W/8.
- One sub-module: rr_pick. It is a combinational round-robin priority picker (request vector, pointer → one-hot winner plus valid), reusable by future multi-master muxes.
- The watchdog counter stays inline; its width is $clog2(TIMEOUT_CYCLES+1).

Test Plan:
- Single master: m0 reads 0x3000_0010; slave acks after 2 cycles with 0xA5A5_0001 → s_stb_o rises 1 cycle after request, m_ack_o[0] pulses with m_dat_o=0xA5A5_0001, grant_o returns to 0 after m0 drops cyc.
- Contention: masters 0..3 all request continuously from reset, each doing single-word writes → grant order 0,1,2,3,0; no master gets a second grant before all others are served.
- Lock: m1 holds cyc high over 3 writes (sel=4'b0011, 4'b1100, 4'b1111) while m2 requests → m2 gets no grant until m1 drops cyc; s_sel_o matches each beat.
- Timeout: TIMEOUT_CYCLES=8, slave never acks m2 → after 8 stalled cycles m_err_o[2] and timeout_o pulse once, s_cyc_o low in that cycle, then the next requester is granted.
- Ack at timeout boundary: slave acks exactly on cycle 8 → m_ack_o asserted, m_err_o and timeout_o stay 0.
- Reset mid-operation: assert wb_rst_ni low while m3 is granted and stalled → s_cyc_o, grant_o and m_ack_o go 0 without waiting for an edge; after release, m0 is granted first when all request.
